regfile_ss: RTL

Parametrised multi-port architectural register file with a per-register busy scoreboard for the ID/WB stages of the N-way superscalar pipeline. It generalises the 2-way file to configurable width, depth and read/write port counts. It adds asynchronous reset clearing, deterministic same-index write priority, producer tracking (busy bits with alloc/flush) and write-conflict reporting. ID reads operands and readiness; dispatch allocates destinations; WB writes results.

---
 rtl/regfile_ss_if.sv | 34 +++
 rtl/regfile_ss.sv | 121 ++++++++++++
 2 files changed

// File: rtl/regfile_ss_if.sv
// Register file port bundle: ID reads, WB writes, dispatch allocs.
// Parameters must match the attached regfile_ss instance.
interface regfile_ss_if #(
    parameter int WIDTH       = 32,
    parameter int NUM_REGS    = 32,
    parameter int READ_PORTS  = 4,
    parameter int WRITE_PORTS = 2
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic [READ_PORTS*IDX_W-1:0]  rd_idx;
    logic [READ_PORTS*WIDTH-1:0]  rd_data;
    logic [READ_PORTS-1:0]        rd_ready;
    logic [WRITE_PORTS-1:0]       wr_en;
    logic [WRITE_PORTS*IDX_W-1:0] wr_idx;
    logic [WRITE_PORTS*WIDTH-1:0] wr_data;
    logic [WRITE_PORTS-1:0]       alloc_en;
    logic [WRITE_PORTS*IDX_W-1:0] alloc_idx;
    logic                         flush;
    logic                         conflict;
    logic [7:0]                   conflict_cnt;

    modport master (
        output rd_idx, wr_en, wr_idx, wr_data,
        output alloc_en, alloc_idx, flush,
        input  rd_data, rd_ready, conflict, conflict_cnt
    );

    modport slave (
        input  rd_idx, wr_en, wr_idx, wr_data,
        input  alloc_en, alloc_idx, flush,
        output rd_data, rd_ready, conflict, conflict_cnt
    );
endinterface

// File: rtl/regfile_ss.sv
// Multi-port register file with busy scoreboard and write-conflict count.
// Optional REGFILE_SS_BYPASS_EN: same-cycle WB-to-ID forwarding.
module regfile_ss #(
    parameter int WIDTH       = 32,
    parameter int NUM_REGS    = 32,
    parameter int READ_PORTS  = 4,
    parameter int WRITE_PORTS = 2
) (
    input logic         clock,
    input logic         reset_n,
    regfile_ss_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [WIDTH-1:0] word_t;

    word_t               regs    [NUM_REGS];
    word_t               regs_nx [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nx;
    logic                collide;
    logic                conflict_q;
    logic [7:0]          cnt_q;

    idx_t  wi [WRITE_PORTS];
    word_t wd [WRITE_PORTS];
    idx_t  ai [WRITE_PORTS];
    idx_t  ri [READ_PORTS];

    function automatic logic valid_idx(idx_t i);
        return (i != '0) && (int'(i) < NUM_REGS);
    endfunction

    for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wp
        assign wi[w] = bus.wr_idx[w*IDX_W +: IDX_W];
        assign wd[w] = bus.wr_data[w*WIDTH +: WIDTH];
        assign ai[w] = bus.alloc_idx[w*IDX_W +: IDX_W];
    end

    // Ascending port order lets the highest-numbered port win.
    always_comb begin
        regs_nx = regs;
        busy_nx = busy;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (bus.wr_en[w] && valid_idx(wi[w])) begin
                regs_nx[wi[w]] = wd[w];
                busy_nx[wi[w]] = 1'b0;
            end
        end
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (bus.alloc_en[w] && valid_idx(ai[w])) begin
                busy_nx[ai[w]] = 1'b1;
            end
        end
        if (bus.flush) begin
            busy_nx = '0;
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            for (int v = w + 1; v < WRITE_PORTS; v++) begin
                if (bus.wr_en[w] && bus.wr_en[v] &&
                    wi[w] == wi[v] && valid_idx(wi[w])) begin
                    collide = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            busy       <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            regs       <= regs_nx;
            busy       <= busy_nx;
            conflict_q <= collide;
            if (collide && cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rp
        assign ri[p] = bus.rd_idx[p*IDX_W +: IDX_W];

        word_t d;
        logic  r;

        always_comb begin
            d = '0;
            r = 1'b1;
            if (valid_idx(ri[p])) begin
                d = regs[ri[p]];
                r = ~busy[ri[p]];
`ifdef REGFILE_SS_BYPASS_EN
                // Forwarding is held off in reset so reads stay 0/ready.
                for (int w = 0; w < WRITE_PORTS; w++) begin
                    if (reset_n && bus.wr_en[w] && wi[w] == ri[p]) begin
                        d = wd[w];
                        r = 1'b1;
                    end
                end
`endif
            end
        end

        assign bus.rd_data[p*WIDTH +: WIDTH] = d;
        assign bus.rd_ready[p]               = r;
    end

    assign bus.conflict     = conflict_q;
    assign bus.conflict_cnt = cnt_q;
endmodule
